// File: rtl/cpu_pkg.sv
// Shared types and defaults for the bus transfer unit.
// Bus-side state encoding and width helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_TX,
    XF_RX
  } xfer_state_t;

  localparam int BUS_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;

  function automatic int beats_of(int dw, int bw);
    return dw / bw;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_unit_if.sv
// Core-side and external-bus signals of the transfer unit.
// master = core/bus environment, slave = the unit itself.
interface bus_xfer_unit_if #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8,
  parameter int NCH    = 3
);

  logic [NCH-1:0]        tx_req;
  logic [NCH*DATA_W-1:0] tx_data;
  logic [NCH-1:0]        tx_ack;
  logic                  rx_req;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic [BUS_W-1:0]      bus_in;
  logic [BUS_W-1:0]      bus_out;
  logic [NCH-1:0]        bus_sel;
  logic                  ext_ready;
  logic                  ext_valid;
  logic                  busy;
  logic                  error;
  logic                  err_clr;

  modport master (
    output tx_req, tx_data, rx_req,
    output bus_in, ext_ready, ext_valid,
    output err_clr,
    input  tx_ack, rx_data, rx_valid,
    input  bus_out, bus_sel, busy, error
  );

  modport slave (
    input  tx_req, tx_data, rx_req,
    input  bus_in, ext_ready, ext_valid,
    input  err_clr,
    output tx_ack, rx_data, rx_valid,
    output bus_out, bus_sel, busy, error
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at/after ptr, wrapping.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
  parameter  int NCH = 3,
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  idx,
  output logic           any
);

  // scan channels starting at ptr, take the first one asking
  always_comb begin : p_grant
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(ptr) + i;
      if (k >= NCH) k = k - NCH;
      if (!any && req[PW'(k)]) begin
        any          = 1'b1;
        gnt[PW'(k)]  = 1'b1;
        idx          = PW'(k);
      end
    end
  end

endmodule

// File: rtl/bus_xfer_unit.sv
// Serialises NCH words onto a narrow bus with round-robin
// grant, deserialises one inbound word, aborts on stall.
module bus_xfer_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BUS_W   = BUS_W_DEF,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  bus_xfer_unit_if.slave xf
);

  localparam int BEATS = beats_of(DATA_W, BUS_W);
  localparam int CW    = $clog2(BEATS + 1);
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int PW    = idx_w(NCH);

  if (DATA_W % BUS_W != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of BUS_W");
  end

  xfer_state_t state, state_nx;

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rx_data_q;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tcnt;
  logic [PW-1:0]     ptr;
  logic [NCH-1:0]    sel_q;
  logic [NCH-1:0]    tx_ack_q;
  logic              rx_valid_q;
  logic              err_q;

  logic [NCH-1:0]    arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;

  logic              start_tx;
  logic              start_rx;
  logic              beat;
  logic              last;
  logic              tmo;

  logic [DATA_W-1:0] words [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_words
    assign words[k] = xf.tx_data[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req (xf.tx_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // next state plus per-cycle control strobes
  always_comb begin
    state_nx = state;
    start_tx = 1'b0;
    start_rx = 1'b0;
    beat     = 1'b0;
    unique case (state)
      XF_IDLE: begin
        if (xf.rx_req) begin
          start_rx = 1'b1;
          state_nx = XF_RX;
        end else if (arb_any) begin
          start_tx = 1'b1;
          state_nx = XF_TX;
        end
      end
      XF_TX:   beat = xf.ext_ready;
      XF_RX:   beat = xf.ext_valid;
      default: state_nx = XF_IDLE;
    endcase
    last = beat && (cnt == CW'(BEATS - 1));
    tmo  = (TIMEOUT > 0) && (state != XF_IDLE)
        && !beat && (tcnt == TW'(TLIM));
    if (last || tmo) state_nx = XF_IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= XF_IDLE;
    else      state <= state_nx;
  end

  // shift register, beat count, grant pointer, done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      rx_data_q  <= '0;
      cnt        <= '0;
      ptr        <= '0;
      sel_q      <= '0;
      tx_ack_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_ack_q   <= '0;
      rx_valid_q <= 1'b0;
      if (start_tx) begin
        shreg <= words[arb_idx];
        cnt   <= '0;
        sel_q <= arb_gnt;
        ptr   <= (arb_idx == PW'(NCH - 1))
               ? '0 : arb_idx + PW'(1);
      end
      if (start_rx) begin
        shreg <= '0;
        cnt   <= '0;
      end
      if (beat) begin
        cnt <= cnt + CW'(1);
        if (state == XF_TX)
          shreg <= shreg << BUS_W;
        else
          shreg <= (shreg << BUS_W)
                 | DATA_W'(xf.bus_in);
      end
      if (last && state == XF_TX)
        tx_ack_q <= sel_q;
      if (last && state == XF_RX) begin
        rx_data_q  <= (shreg << BUS_W)
                    | DATA_W'(xf.bus_in);
        rx_valid_q <= 1'b1;
      end
    end
  end

  // idle-cycle counter, restarted by every beat and in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tcnt <= '0;
    else if (state == XF_IDLE || beat || tmo)
      tcnt <= '0;
    else
      tcnt <= tcnt + TW'(1);
  end

  // sticky timeout flag, clear wins over set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            err_q <= 1'b0;
    else if (xf.err_clr) err_q <= 1'b0;
    else if (tmo)        err_q <= 1'b1;
  end

  assign xf.bus_out  = (state == XF_TX)
                     ? shreg[DATA_W-1 -: BUS_W] : '0;
  assign xf.bus_sel  = (state == XF_TX) ? sel_q : '0;
  assign xf.busy     = (state != XF_IDLE);
  assign xf.tx_ack   = tx_ack_q;
  assign xf.rx_valid = rx_valid_q;
  assign xf.rx_data  = rx_data_q;
  assign xf.error    = err_q;

endmodule
